// File: rtl/fifo_rd_stream.sv
// Read-side streaming adapter: pulls words from a show-ahead FIFO
// into a 2-entry skid buffer and presents them on a valid/ready port.
module fifo_rd_stream #(
  parameter int DBITWIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 enable,
  input  logic                 fifo_empty,
  input  logic [DBITWIDTH-1:0] fifo_rdata,
  output logic                 fifo_read,
  output logic                 out_valid,
  output logic [DBITWIDTH-1:0] out_data,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] word_cnt,
  output logic                 busy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [DBITWIDTH-1:0] head;
  logic [DBITWIDTH-1:0] tail;
  logic [DBITWIDTH-1:0] head_nxt;
  logic [DBITWIDTH-1:0] tail_nxt;
  logic                 pop;

  // Read decision uses only registered state, never out_ready.
  assign fifo_read = enable & ~fifo_empty & ~clr & (state != TWO);
  assign out_valid = (state != EMPTY);
  assign busy      = out_valid;
  assign out_data  = head;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    head_nxt  = head;
    tail_nxt  = tail;
    unique case (state)
      EMPTY: begin
        if (fifo_read) begin
          state_nxt = ONE;
          head_nxt  = fifo_rdata;
        end
      end
      ONE: begin
        unique case (1'b1)
          fifo_read && !pop: begin
            state_nxt = TWO;
            tail_nxt  = fifo_rdata;
          end
          !fifo_read && pop: begin
            state_nxt = EMPTY;
          end
          fifo_read && pop: begin
            head_nxt  = fifo_rdata;
          end
          default: ;
        endcase
      end
      TWO: begin
        if (pop) begin
          state_nxt = ONE;
          head_nxt  = tail;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= EMPTY;
      word_cnt <= '0;
    end else begin
      state    <= state_nxt;
      word_cnt <= word_cnt + {{(CNT_WIDTH-1){1'b0}}, pop};
    end
  end

  // Payload registers carry no reset; contents are ignored while EMPTY.
  always_ff @(posedge clk) begin
    head <= head_nxt;
    tail <= tail_nxt;
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: FIFO model feeds the DUT,
// expected words are queued at push time and checked on each pop.
module tb_fifo_rd_stream;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        enable = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_rdata = '0;
  logic        out_ready = 1'b0;
  logic        fifo_read;
  logic        out_valid;
  logic [31:0] out_data;
  logic [15:0] word_cnt;
  logic        busy;
  logic        fifo_read4;
  logic        out_valid4;
  logic [31:0] out_data4;
  logic [3:0]  word_cnt4;
  logic        busy4;

  fifo_rd_stream #(.DBITWIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .clr(clr), .enable(enable),
    .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_read(fifo_read), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready),
    .word_cnt(word_cnt), .busy(busy)
  );

  fifo_rd_stream #(.DBITWIDTH(32), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .clr(clr), .enable(enable),
    .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_read(fifo_read4), .out_valid(out_valid4),
    .out_data(out_data4), .out_ready(out_ready),
    .word_cnt(word_cnt4), .busy(busy4)
  );

  always #5 clk = ~clk;

  logic [31:0] fifo_q[$];
  logic [31:0] exp_q[$];
  int          occ = 0;
  int          cnt_m = 0;
  int          rd_total = 0;
  int          checks = 0;
  int          failures = 0;
  bit          stall_prev = 0;
  logic [31:0] stall_data = '0;

  task automatic push_word(input logic [31:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic step(input logic rdy, input logic en, input logic hold);
    logic        exp_rd;
    logic        rd_s;
    logic        popm;
    logic [31:0] w;
    logic [15:0] cm;
    @(negedge clk);
    clr = 1'b0;
    out_ready = rdy;
    enable = en;
    fifo_empty = hold || (fifo_q.size() == 0);
    fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
    #1;
    checks++;
    if (out_valid !== (occ != 0) || busy !== (occ != 0)) begin
      failures++;
      $display("FAIL valid_busy: out_valid=%b busy=%b required=%b",
               out_valid, busy, occ != 0);
    end
    exp_rd = en && !fifo_empty && (occ != 2);
    checks++;
    if (fifo_read !== exp_rd) begin
      failures++;
      $display("FAIL fifo_read: got=%b required=%b empty=%b occ=%0d",
               fifo_read, exp_rd, fifo_empty, occ);
    end
    if (stall_prev) begin
      checks++;
      if (out_data !== stall_data) begin
        failures++;
        $display("FAIL stall_stable: out_data=%h required=%h",
                 out_data, stall_data);
      end
    end
    popm = (occ != 0) && rdy;
    if (popm) begin
      w = exp_q.pop_front();
      checks++;
      if (out_data !== w) begin
        failures++;
        $display("FAIL order: out_data=%h required=%h", out_data, w);
      end
      cnt_m++;
    end
    stall_prev = (occ != 0) && !rdy;
    stall_data = out_data;
    rd_s = fifo_read;
    @(posedge clk);
    if (rd_s === 1'b1 && fifo_q.size() != 0) begin
      void'(fifo_q.pop_front());
      occ++;
      rd_total++;
    end
    if (popm) occ--;
    cm = cnt_m[15:0];
  endtask

  task automatic check_cnt(input string name);
    logic [15:0] c16;
    logic [3:0]  c4;
    c16 = cnt_m[15:0];
    c4 = cnt_m[3:0];
    #1;
    checks++;
    if (word_cnt !== c16) begin
      failures++;
      $display("FAIL %s word_cnt: got=%0d required=%0d", name, word_cnt, c16);
    end
    checks++;
    if (word_cnt4 !== c4) begin
      failures++;
      $display("FAIL %s word_cnt4: got=%0d required=%0d", name, word_cnt4, c4);
    end
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    enable = 1'b1;
    out_ready = 1'b1;
    fifo_empty = (fifo_q.size() == 0);
    fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
    #1;
    checks++;
    if (fifo_read !== 1'b0) begin
      failures++;
      $display("FAIL clr_read: fifo_read=%b required=0", fifo_read);
    end
    @(posedge clk);
    repeat (occ) void'(exp_q.pop_front());
    occ = 0;
    cnt_m = 0;
    stall_prev = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL clr_state: out_valid=%b busy=%b required=0",
               out_valid, busy);
    end
    check_cnt("clr");
  endtask

  task automatic drain(input string name, input int bound);
    int n = 0;
    while ((exp_q.size() != 0) && (n < bound)) begin
      step(1'b1, 1'b1, 1'b0);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: left=%0d required=0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_clr();
    do_clr();
  endtask

  task automatic test_single();
    do_clr();
    push_word(32'hA5A5_0001);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check_cnt("single");
    step(1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    int r0;
    do_clr();
    for (int i = 0; i < 5; i++) push_word(32'hB000_0000 + i);
    r0 = rd_total;
    repeat (6) step(1'b0, 1'b1, 1'b0);
    checks++;
    if (rd_total - r0 != 2 || occ != 2) begin
      failures++;
      $display("FAIL bp_reads: reads=%0d required=2", rd_total - r0);
    end
    repeat (8) step(1'b1, 1'b1, 1'b0);
    check_cnt("backpressure");
  endtask

  task automatic test_back_to_back();
    do_clr();
    for (int i = 0; i < 100; i++) push_word(32'hC000_0000 + i);
    repeat (101) step(1'b1, 1'b1, 1'b0);
    check_cnt("stream");
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL stream_left: left=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_random();
    do_clr();
    for (int i = 0; i < 10000; i++) push_word($urandom);
    for (int n = 0; n < 60000 && exp_q.size() != 0; n++)
      step(1'($urandom_range(0, 1)), 1'b1, ($urandom_range(0, 9) < 3));
    drain("random", 100);
    check_cnt("random");
  endtask

  task automatic test_wrap();
    do_clr();
    for (int i = 0; i < 17; i++) push_word(32'hD000_0000 + i);
    drain("wrap", 100);
    check_cnt("wrap");
  endtask

  task automatic test_clr_two();
    do_clr();
    for (int i = 0; i < 5; i++) push_word(32'hE000_0000 + i);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    do_clr();
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (occ != 0 || exp_q.size() != 2) begin
      failures++;
      $display("FAIL enable_drain: occ=%0d left=%0d required=0,2",
               occ, exp_q.size());
    end
    drain("clr_two", 20);
    check_cnt("clr_two");
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_wrap();
    test_clr_two();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
